// File: rtl/cbus_arbiter.sv
// cbus_arbiter: locking N-to-1 arbiter for the cached bus (CBus).
// One master is granted and keeps the bus until its transaction ends with
// ready && last. After that the arbiter spends one IDLE cycle re-arbitrating.
// Configuration macro CBUS_ARBITER_RR_EN:
//   defined   - round-robin arbitration; priority pointer advances past the
//               master that just completed.
//   undefined - fixed priority; lowest index wins (pointer tied to 0).

package cbus_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [15:0] addr;
    logic [31:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  localparam int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  cbus_req_t [NUM_INPUTS-1:0]  ireqs,
  output cbus_resp_t [NUM_INPUTS-1:0] iresps,
  output cbus_req_t                   oreq,
  input  cbus_resp_t                  oresp,
  output logic                        busy,
  output logic [IDX_W-1:0]            grant_idx
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] grant_next;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic [IDX_W-1:0] cand;
  int               sum;

`ifdef CBUS_ARBITER_RR_EN
  logic [IDX_W-1:0] ptr_next;

  // Priority pointer register; only advances on transaction completion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end
`else
  assign ptr = '0;
`endif

  // FSM state and grant index register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      grant_idx <= '0;
    end else begin
      state     <= state_next;
      grant_idx <= grant_next;
    end
  end

  // Scan from ptr upward with explicit wrap so non-power-of-two counts work.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    sum    = 0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_INPUTS) begin
        sum = sum - NUM_INPUTS;
      end
      cand = IDX_W'(sum);
      if (!found && ireqs[cand].valid) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state logic and the combinational request/response muxing.
  always_comb begin
    state_next = state;
    grant_next = grant_idx;
`ifdef CBUS_ARBITER_RR_EN
    ptr_next   = ptr;
`endif
    oreq       = '0;
    iresps     = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          grant_next = winner;
          state_next = BUSY;
        end
      end
      BUSY: begin
        oreq              = ireqs[grant_idx];
        iresps[grant_idx] = oresp;
        if (oresp.ready && oresp.last) begin
          state_next = IDLE;
`ifdef CBUS_ARBITER_RR_EN
          ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDX_W'(1);
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_cbus_arbiter.sv
// Testbench for cbus_arbiter: a 3-port instance driven from a vector table
// (arbitration order, wrap) and a 2-port instance driven by hand-written
// sequences (bursts, locking, backpressure, reset mid-burst).

module tb_cbus_arbiter;
  import cbus_pkg::*;

`ifdef CBUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic resetn;

  cbus_req_t  [1:0] ireqs2;
  cbus_resp_t [1:0] iresps2;
  cbus_req_t        oreq2;
  cbus_resp_t       oresp2;
  logic             busy2;
  logic             gidx2;

  cbus_req_t  [2:0] ireqs3;
  cbus_resp_t [2:0] iresps3;
  cbus_req_t        oreq3;
  cbus_resp_t       oresp3;
  logic             busy3;
  logic [1:0]       gidx3;

  int checks = 0;
  int errors = 0;

  cbus_arbiter #(.NUM_INPUTS(2)) dut2 (
    .clk(clk), .resetn(resetn), .ireqs(ireqs2), .iresps(iresps2),
    .oreq(oreq2), .oresp(oresp2), .busy(busy2), .grant_idx(gidx2)
  );

  cbus_arbiter #(.NUM_INPUTS(3)) dut3 (
    .clk(clk), .resetn(resetn), .ireqs(ireqs3), .iresps(iresps3),
    .oreq(oreq3), .oresp(oresp3), .busy(busy3), .grant_idx(gidx3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the stimulus is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [2:0] valid;
    logic       ready;
    logic       last;
    logic       exp_busy;
    logic [1:0] exp_g;
    logic [2:0] exp_mask;
  } vec_t;

  vec_t tbl [20];

  function automatic cbus_req_t mk_req(logic v, logic w, logic [15:0] a, logic [31:0] d);
    cbus_req_t r;
    r.valid = v;
    r.write = w;
    r.addr  = a;
    r.data  = d;
    return r;
  endfunction

  function automatic cbus_resp_t mk_resp(logic rdy, logic lst, logic [31:0] d);
    cbus_resp_t r;
    r.ready = rdy;
    r.last  = lst;
    r.data  = d;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0]  mask;
    logic [15:0] exp_addr;

    // Round-robin order with all three ports requesting, then wrap cases.
    tbl[0]  = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000};
    tbl[1]  = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[2]  = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000};
    tbl[3]  = '{3'b111, 1'b1, 1'b1, 1'b1, RR ? 2'd1 : 2'd0, RR ? 3'b010 : 3'b001};
    tbl[4]  = '{3'b111, 1'b1, 1'b1, 1'b0, RR ? 2'd1 : 2'd0, 3'b000};
    tbl[5]  = '{3'b111, 1'b1, 1'b1, 1'b1, RR ? 2'd2 : 2'd0, RR ? 3'b100 : 3'b001};
    tbl[6]  = '{3'b111, 1'b1, 1'b1, 1'b0, RR ? 2'd2 : 2'd0, 3'b000};
    tbl[7]  = '{3'b111, 1'b1, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[8]  = '{3'b111, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000};
    tbl[9]  = '{3'b111, 1'b1, 1'b1, 1'b1, RR ? 2'd1 : 2'd0, RR ? 3'b010 : 3'b001};
    tbl[10] = '{3'b111, 1'b1, 1'b1, 1'b0, RR ? 2'd1 : 2'd0, 3'b000};
    tbl[11] = '{3'b111, 1'b1, 1'b1, 1'b1, RR ? 2'd2 : 2'd0, RR ? 3'b100 : 3'b001};
    tbl[12] = '{3'b010, 1'b1, 1'b1, 1'b0, RR ? 2'd2 : 2'd0, 3'b000};
    tbl[13] = '{3'b010, 1'b1, 1'b1, 1'b1, 2'd1, 3'b010};
    tbl[14] = '{3'b001, 1'b1, 1'b1, 1'b0, 2'd1, 3'b000};
    tbl[15] = '{3'b001, 1'b1, 1'b1, 1'b1, 2'd0, 3'b001};
    tbl[16] = '{3'b101, 1'b1, 1'b1, 1'b0, 2'd0, 3'b000};
    tbl[17] = '{3'b101, 1'b1, 1'b1, 1'b1, RR ? 2'd2 : 2'd0, RR ? 3'b100 : 3'b001};
    tbl[18] = '{3'b000, 1'b1, 1'b1, 1'b0, RR ? 2'd2 : 2'd0, 3'b000};
    tbl[19] = '{3'b000, 1'b1, 1'b1, 1'b0, RR ? 2'd2 : 2'd0, 3'b000};

    // Reset with requests present: outputs must stay quiet.
    resetn = 1'b0;
    ireqs2 = '0;
    oresp2 = '0;
    for (int i = 0; i < 3; i++) ireqs3[i] = mk_req(1'b1, 1'b0, 16'(16'h100 * i), 32'hC0 + i);
    oresp3 = mk_resp(1'b1, 1'b1, 32'hD0);
    step();
    step();
    chk("rst_busy3", {31'd0, busy3}, 32'd0);
    chk("rst_gidx3", {30'd0, gidx3}, 32'd0);
    chk("rst_oreq3_valid", {31'd0, oreq3.valid}, 32'd0);
    chk("rst_busy2", {31'd0, busy2}, 32'd0);
    chk("rst_iresps3", {29'd0, iresps3[2].ready, iresps3[1].ready, iresps3[0].ready}, 32'd0);
    resetn = 1'b1;

    for (int v = 0; v < 20; v++) begin
      for (int i = 0; i < 3; i++) begin
        ireqs3[i] = mk_req(tbl[v].valid[i], 1'b0, 16'(16'h100 * i), 32'hC0 + i);
      end
      oresp3 = mk_resp(tbl[v].ready, tbl[v].last, 32'hD00 + v);
      #1;
      mask     = {iresps3[2].ready, iresps3[1].ready, iresps3[0].ready};
      exp_addr = tbl[v].exp_busy ? 16'(16'h100 * tbl[v].exp_g) : 16'h0;
      chk($sformatf("v%0d_busy", v), {31'd0, busy3}, {31'd0, tbl[v].exp_busy});
      chk($sformatf("v%0d_gidx", v), {30'd0, gidx3}, {30'd0, tbl[v].exp_g});
      chk($sformatf("v%0d_ovalid", v), {31'd0, oreq3.valid}, {31'd0, tbl[v].exp_busy});
      chk($sformatf("v%0d_oaddr", v), {16'd0, oreq3.addr}, {16'd0, exp_addr});
      chk($sformatf("v%0d_rmask", v), {29'd0, mask}, {29'd0, tbl[v].exp_mask});
      step();
    end
    ireqs3 = '0;
    oresp3 = '0;

    // Single master, 4-beat read on port 0.
    ireqs2[0] = mk_req(1'b1, 1'b0, 16'h40, 32'h0);
    oresp2    = '0;
    #1;
    chk("sm_req_cycle_ovalid", {31'd0, oreq2.valid}, 32'd0);
    chk("sm_req_cycle_busy", {31'd0, busy2}, 32'd0);
    step();
    for (int b = 0; b < 4; b++) begin
      oresp2 = mk_resp(1'b1, b == 3, 32'hA0 + b);
      #1;
      chk($sformatf("sm_b%0d_ovalid", b), {31'd0, oreq2.valid}, 32'd1);
      chk($sformatf("sm_b%0d_oaddr", b), {16'd0, oreq2.addr}, 32'h40);
      chk($sformatf("sm_b%0d_rdata", b), iresps2[0].data, 32'hA0 + b);
      chk($sformatf("sm_b%0d_rlast", b), {31'd0, iresps2[0].last}, (b == 3) ? 32'd1 : 32'd0);
      chk($sformatf("sm_b%0d_port1", b), {30'd0, iresps2[1].ready, iresps2[1].last}, 32'd0);
      step();
    end
    ireqs2[0] = '0;
    oresp2    = '0;
    #1;
    chk("sm_after_busy", {31'd0, busy2}, 32'd0);
    chk("sm_after_ovalid", {31'd0, oreq2.valid}, 32'd0);
    step();

    // Lock: port 1 holds an 8-beat burst while port 0 starts requesting.
    ireqs2[1] = mk_req(1'b1, 1'b0, 16'h80, 32'h0);
    #1;
    step();
    for (int b = 0; b < 8; b++) begin
      if (b == 2) ireqs2[0] = mk_req(1'b1, 1'b0, 16'h40, 32'h0);
      oresp2 = mk_resp(1'b1, b == 7, 32'(b));
      #1;
      chk($sformatf("lk_b%0d_oaddr", b), {16'd0, oreq2.addr}, 32'h80);
      chk($sformatf("lk_b%0d_gidx", b), {31'd0, gidx2}, 32'd1);
      chk($sformatf("lk_b%0d_p0ready", b), {31'd0, iresps2[0].ready}, 32'd0);
      step();
    end
    ireqs2[1] = '0;
    oresp2    = '0;
    #1;
    chk("lk_idle_busy", {31'd0, busy2}, 32'd0);
    step();
    chk("lk_p0_busy", {31'd0, busy2}, 32'd1);
    chk("lk_p0_gidx", {31'd0, gidx2}, 32'd0);
    chk("lk_p0_oaddr", {16'd0, oreq2.addr}, 32'h40);
    oresp2 = mk_resp(1'b1, 1'b1, 32'h0);
    step();
    ireqs2[0] = '0;
    oresp2    = '0;
    step();

    // Backpressure: ready low for 5 cycles, then ready with last.
    ireqs2[0] = mk_req(1'b1, 1'b1, 16'h44, 32'h55);
    #1;
    step();
    for (int c = 0; c < 5; c++) begin
      oresp2 = mk_resp(1'b0, 1'b0, 32'h0);
      #1;
      chk($sformatf("bp_c%0d_busy", c), {31'd0, busy2}, 32'd1);
      chk($sformatf("bp_c%0d_odata", c), oreq2.data, 32'h55);
      chk($sformatf("bp_c%0d_oaddr", c), {16'd0, oreq2.addr}, 32'h44);
      step();
    end
    oresp2 = mk_resp(1'b1, 1'b1, 32'h0);
    #1;
    chk("bp_final_rlast", {31'd0, iresps2[0].last}, 32'd1);
    step();
    ireqs2[0] = '0;
    oresp2    = '0;
    #1;
    chk("bp_idle_busy", {31'd0, busy2}, 32'd0);
    step();

    // Reset mid-burst on a port 1 write, then a fresh request on port 1.
    ireqs2[1] = mk_req(1'b1, 1'b1, 16'h90, 32'h77);
    #1;
    step();
    oresp2 = mk_resp(1'b1, 1'b0, 32'h0);
    step();
    #1;
    chk("rm_b1_busy", {31'd0, busy2}, 32'd1);
    chk("rm_b1_gidx", {31'd0, gidx2}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rm_rst_ovalid", {31'd0, oreq2.valid}, 32'd0);
    chk("rm_rst_busy", {31'd0, busy2}, 32'd0);
    chk("rm_rst_gidx", {31'd0, gidx2}, 32'd0);
    chk("rm_rst_p1ready", {31'd0, iresps2[1].ready}, 32'd0);
    ireqs2[1] = '0;
    oresp2    = '0;
    step();
    resetn    = 1'b1;
    ireqs2[1] = mk_req(1'b1, 1'b0, 16'hA8, 32'h0);
    #1;
    chk("rm_fresh_idle", {31'd0, busy2}, 32'd0);
    step();
    chk("rm_fresh_busy", {31'd0, busy2}, 32'd1);
    chk("rm_fresh_gidx", {31'd0, gidx2}, 32'd1);
    chk("rm_fresh_oaddr", {16'd0, oreq2.addr}, 32'hA8);
    oresp2 = mk_resp(1'b1, 1'b1, 32'h0);
    step();
    ireqs2[1] = '0;
    oresp2    = '0;
    #1;
    chk("rm_done_busy", {31'd0, busy2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
